// File: rtl/ray_setup.sv
// ray_setup: converts one accepted pixel coordinate into a signed fixed-point
// camera-space ray direction and offers it to the ray core over valid/ready.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pixel_x, pixel_y, valid    pixel from the thread generator
//   ray_core_free              high while idle (ready for a pixel)
//   ray_dir_x/y/z              signed direction, FRAC fractional bits
//   ray_pix_x/y                echo of the pixel behind the current ray
//   ray_valid, ray_ready       handshake towards the ray core
//   frame_done                 one-cycle pulse after the last pixel's ray is taken
//   oob_err                    sticky out-of-range pixel flag
module ray_setup #(
   parameter int unsigned SCREEN_W  = 640,
   parameter int unsigned SCREEN_H  = 480,
   parameter int unsigned FRAC      = 8,
   parameter int unsigned DIR_W     = 16,
   parameter int unsigned PIX_SCALE = 4,
   parameter int          FOCAL     = 5 * (1 << FRAC)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [9:0]              pixel_x,
   input  logic [9:0]              pixel_y,
   input  logic                    valid,
   output logic                    ray_core_free,
   output logic signed [DIR_W-1:0] ray_dir_x,
   output logic signed [DIR_W-1:0] ray_dir_y,
   output logic signed [DIR_W-1:0] ray_dir_z,
   output logic [9:0]              ray_pix_x,
   output logic [9:0]              ray_pix_y,
   output logic                    ray_valid,
   input  logic                    ray_ready,
   output logic                    frame_done,
   output logic                    oob_err
);

   localparam int unsigned CW     = 11;
   localparam int unsigned PROD_W = CW + 33;

   localparam logic [9:0]              LAST_X  = 10'(SCREEN_W - 1);
   localparam logic [9:0]              LAST_Y  = 10'(SCREEN_H - 1);
   localparam logic signed [CW-1:0]    HALF_W  = CW'(SCREEN_W / 2);
   localparam logic signed [CW-1:0]    HALF_H  = CW'(SCREEN_H / 2);
   localparam logic signed [PROD_W-1:0] SCALE_S = PROD_W'(PIX_SCALE);
   localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((64'(1) << DIR_W) >> 1) - PROD_W'(1);
   localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic signed [DIR_W-1:0] DIR_MAX = {1'b0, {(DIR_W-1){1'b1}}};
   localparam logic signed [DIR_W-1:0] DIR_MIN = {1'b1, {(DIR_W-1){1'b0}}};
   localparam logic signed [DIR_W-1:0] FOCAL_D = DIR_W'(FOCAL);

   typedef enum logic [1:0] {IDLE, CENTER, SCALE, HOLD} state_t;

   state_t                   state_q, state_d;
   logic signed [CW-1:0]     cx_q, cx_d, cy_q, cy_d;
   logic signed [DIR_W-1:0]  dir_x_d, dir_y_d, dir_z_d;
   logic [9:0]               pix_x_d, pix_y_d;
   logic                     valid_d, frame_done_d, oob_d, free_d;
   logic signed [PROD_W-1:0] px_full, py_full;
   logic                     pix_oob;

   // Clamp a full-precision product into the signed DIR_W range.
   function automatic logic signed [DIR_W-1:0] sat_dir(input logic signed [PROD_W-1:0] p);
      if (p > SAT_MAX)      sat_dir = DIR_MAX;
      else if (p < SAT_MIN) sat_dir = DIR_MIN;
      else                  sat_dir = DIR_W'(p);
   endfunction

   assign px_full = PROD_W'(cx_q) * SCALE_S;
   assign py_full = PROD_W'(cy_q) * SCALE_S;
   assign pix_oob = (32'(pixel_x) >= SCREEN_W) || (32'(pixel_y) >= SCREEN_H);

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      dir_x_d      = ray_dir_x;
      dir_y_d      = ray_dir_y;
      dir_z_d      = ray_dir_z;
      pix_x_d      = ray_pix_x;
      pix_y_d      = ray_pix_y;
      valid_d      = ray_valid;
      frame_done_d = 1'b0;
      oob_d        = oob_err;
      case (state_q)
         IDLE: begin
            if (valid) begin
               if (pix_oob) begin
                  oob_d = 1'b1;
               end else begin
                  pix_x_d = pixel_x;
                  pix_y_d = pixel_y;
                  state_d = CENTER;
               end
            end
         end
         CENTER: begin
            // +y points up, so the row offset is inverted.
            cx_d    = $signed({1'b0, ray_pix_x}) - HALF_W;
            cy_d    = HALF_H - $signed({1'b0, ray_pix_y});
            state_d = SCALE;
         end
         SCALE: begin
            dir_x_d = sat_dir(px_full);
            dir_y_d = sat_dir(py_full);
            dir_z_d = FOCAL_D;
            valid_d = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (ray_valid && ray_ready) begin
               valid_d      = 1'b0;
               frame_done_d = (ray_pix_x == LAST_X) && (ray_pix_y == LAST_Y);
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      free_d = (state_d == IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cx_q          <= '0;
         cy_q          <= '0;
         ray_dir_x     <= '0;
         ray_dir_y     <= '0;
         ray_dir_z     <= '0;
         ray_pix_x     <= '0;
         ray_pix_y     <= '0;
         ray_valid     <= 1'b0;
         frame_done    <= 1'b0;
         oob_err       <= 1'b0;
         ray_core_free <= 1'b1;
      end else begin
         state_q       <= state_d;
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         ray_dir_x     <= dir_x_d;
         ray_dir_y     <= dir_y_d;
         ray_dir_z     <= dir_z_d;
         ray_pix_x     <= pix_x_d;
         ray_pix_y     <= pix_y_d;
         ray_valid     <= valid_d;
         frame_done    <= frame_done_d;
         oob_err       <= oob_d;
         ray_core_free <= free_d;
      end
   end

endmodule

// File: tb/tb_ray_setup.sv
// Testbench for ray_setup: directed cases plus randomized pixels, checked by a
// queue-based scoreboard fed from a behavioural model.
module tb_ray_setup;

   localparam int W = 640;
   localparam int H = 480;
   localparam int FOC = 1280;

   typedef struct {
      int x;
      int y;
      int z;
      int px;
      int py;
   } ray_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, valid, ray_ready;
   logic [9:0]  pixel_x, pixel_y;
   logic        ray_core_free, ray_valid, frame_done, oob_err;
   logic [15:0] ray_dir_x, ray_dir_y, ray_dir_z;
   logic [9:0]  ray_pix_x, ray_pix_y;

   logic        s_valid, s_ready;
   logic [9:0]  s_px, s_py;
   logic        s_free, s_ray_valid, s_frame_done, s_oob;
   logic [15:0] s_dx, s_dy, s_dz;
   logic [9:0]  s_rpx, s_rpy;

   ray_setup dut (
      .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .valid(valid),
      .ray_core_free(ray_core_free), .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y),
      .ray_dir_z(ray_dir_z), .ray_pix_x(ray_pix_x), .ray_pix_y(ray_pix_y),
      .ray_valid(ray_valid), .ray_ready(ray_ready), .frame_done(frame_done),
      .oob_err(oob_err)
   );

   ray_setup #(.PIX_SCALE(128)) dut_sat (
      .clk(clk), .rst(rst), .pixel_x(s_px), .pixel_y(s_py), .valid(s_valid),
      .ray_core_free(s_free), .ray_dir_x(s_dx), .ray_dir_y(s_dy),
      .ray_dir_z(s_dz), .ray_pix_x(s_rpx), .ray_pix_y(s_rpy),
      .ray_valid(s_ray_valid), .ray_ready(s_ready), .frame_done(s_frame_done),
      .oob_err(s_oob)
   );

   int   checks = 0;
   int   failures = 0;
   ray_t q[$];
   bit   exp_oob = 1'b0;
   bit   rnd_ready = 1'b0;
   int   fd_count = 0;
   int   exp_fd_count = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Reference: centre the pixel, scale, clamp; z is the focal constant.
   function automatic ray_t model(input int x, input int y, input int scale);
      ray_t r;
      r.x  = sat16((x - W / 2) * scale);
      r.y  = sat16((H / 2 - y) * scale);
      r.z  = FOC;
      r.px = x;
      r.py = y;
      return r;
   endfunction

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   // Offer one pixel to the main instance once it is free.
   task automatic send(input int x, input int y);
      int n = 0;
      while (!ray_core_free && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("free_timeout", 0, 1);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      valid   = 1'b1;
      if (x < W && y < H) q.push_back(model(x, y, 4));
      else exp_oob = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   always @(posedge clk) begin
      if (rnd_ready) begin
         #1;
         ray_ready = ($urandom_range(0, 1) == 1);
      end
   end

   // Monitor: pops expectations on each handshake, checks hold stability
   // and the frame_done pulse.
   bit   exp_fd = 1'b0;
   bit   hold_chk = 1'b0;
   ray_t held;
   always @(negedge clk) begin
      if (rst) begin
         exp_fd   = 1'b0;
         hold_chk = 1'b0;
      end else begin
         if (frame_done || exp_fd) chk("frame_done", int'(frame_done), int'(exp_fd));
         if (frame_done) fd_count++;
         exp_fd = 1'b0;
         if (hold_chk) begin
            if (!ray_valid) chk("ray_dropped", 0, 1);
            else begin
               chk("hold_x", sx(ray_dir_x), held.x);
               chk("hold_y", sx(ray_dir_y), held.y);
               chk("hold_px", int'(ray_pix_x), held.px);
            end
         end
         hold_chk = 1'b0;
         if (ray_valid && ray_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_ray", int'(ray_pix_x), -1);
            end else begin
               ray_t e;
               e = q.pop_front();
               chk("dir_x", sx(ray_dir_x), e.x);
               chk("dir_y", sx(ray_dir_y), e.y);
               chk("dir_z", sx(ray_dir_z), e.z);
               chk("pix_x", int'(ray_pix_x), e.px);
               chk("pix_y", int'(ray_pix_y), e.py);
               exp_fd = (e.px == W - 1) && (e.py == H - 1);
               if (exp_fd) exp_fd_count++;
            end
         end else if (ray_valid) begin
            held.x   = sx(ray_dir_x);
            held.y   = sx(ray_dir_y);
            held.px  = int'(ray_pix_x);
            hold_chk = 1'b1;
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; ray_ready = 1'b0; pixel_x = '0; pixel_y = '0;
      s_valid = 1'b0; s_ready = 1'b0; s_px = '0; s_py = '0;
      tick(3);
      rst = 1'b0;
      chk("rst_valid", int'(ray_valid), 0);
      chk("rst_free", int'(ray_core_free), 1);
      chk("rst_dir", sx(ray_dir_x) | sx(ray_dir_y) | sx(ray_dir_z), 0);
      chk("rst_pix", int'(ray_pix_x) | int'(ray_pix_y), 0);
      chk("rst_flags", int'(frame_done) | int'(oob_err), 0);
      tick(2);
      chk("idle_no_ray", int'(ray_valid), 0);

      // Pixel (0,0) with ready held high: exact latency.
      ray_ready = 1'b1;
      send(0, 0);
      chk("lat_e1_valid", int'(ray_valid), 0);
      chk("lat_e1_free", int'(ray_core_free), 0);
      tick(1);
      chk("lat_e2_valid", int'(ray_valid), 0);
      tick(1);
      chk("lat_e3_valid", int'(ray_valid), 1);
      chk("lat_e3_free", int'(ray_core_free), 0);
      tick(1);
      chk("lat_e4_valid", int'(ray_valid), 0);
      chk("lat_e4_free", int'(ray_core_free), 1);

      // Last pixel of the frame.
      send(W - 1, H - 1);
      tick(3);
      chk("fd_pulse", int'(frame_done), 1);
      tick(1);
      chk("fd_width", int'(frame_done), 0);

      // Backpressure with an ignored valid pulse during the hold.
      ray_ready = 1'b0;
      send(320, 240);
      tick(2);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", int'(ray_valid), 1);
         chk("bp_free", int'(ray_core_free), 0);
         if (i == 1) begin
            pixel_x = 10'd7; pixel_y = 10'd7; valid = 1'b1;
         end else begin
            valid = 1'b0;
         end
         tick(1);
      end
      ray_ready = 1'b1;
      tick(1);
      ray_ready = 1'b0;
      chk("bp_done_valid", int'(ray_valid), 0);
      chk("bp_done_free", int'(ray_core_free), 1);
      tick(4);
      chk("bp_no_second", int'(ray_valid), 0);

      // Out-of-range pixel dropped, flag sticky, next pixel still served.
      send(640, 10);
      chk("oob_set", int'(oob_err), 1);
      chk("oob_free", int'(ray_core_free), 1);
      tick(4);
      chk("oob_no_ray", int'(ray_valid), 0);
      ray_ready = 1'b1;
      send(1, 1);
      drain();
      chk("oob_sticky", int'(oob_err), 1);

      // Randomized pixels with random backpressure.
      rnd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i % 13 == 5) send(W - 1, H - 1);
         else send(int'($urandom_range(0, 679)), int'($urandom_range(0, 509)));
      end
      drain();
      rnd_ready = 1'b0;
      #2;
      ray_ready = 1'b0;
      chk("rnd_oob", int'(oob_err), int'(exp_oob));
      chk("fd_count", fd_count, exp_fd_count);

      // Reset while holding a ray: the ray is discarded.
      send(100, 100);
      tick(2);
      chk("rh_valid", int'(ray_valid), 1);
      rst = 1'b1;
      q.delete();
      exp_oob = 1'b0;
      tick(1);
      chk("rh_cleared", int'(ray_valid), 0);
      chk("rh_free", int'(ray_core_free), 1);
      rst = 1'b0;
      ray_ready = 1'b1;
      tick(5);
      chk("rh_never", int'(ray_valid), 0);
      chk("rh_oob", int'(oob_err), int'(exp_oob));
      ray_ready = 1'b0;

      // Saturating instance (PIX_SCALE = 128).
      s_px = 10'd0; s_py = 10'd0; s_valid = 1'b1;
      tick(1);
      s_valid = 1'b0;
      tick(2);
      chk("sat_valid", int'(s_ray_valid), 1);
      chk("sat_x_neg", sx(s_dx), model(0, 0, 128).x);
      chk("sat_y", sx(s_dy), model(0, 0, 128).y);
      chk("sat_z", sx(s_dz), FOC);
      s_ready = 1'b1;
      tick(1);
      s_ready = 1'b0;
      chk("sat_done", int'(s_ray_valid), 0);
      s_px = 10'(W - 1); s_py = 10'(H - 1); s_valid = 1'b1;
      tick(1);
      s_valid = 1'b0;
      tick(2);
      chk("sat_x_pos", sx(s_dx), model(W - 1, H - 1, 128).x);
      chk("sat_y2", sx(s_dy), model(W - 1, H - 1, 128).y);
      s_ready = 1'b1;
      tick(1);
      s_ready = 1'b0;
      chk("sat_fd", int'(s_frame_done), 1);
      tick(1);
      chk("sat_fd_width", int'(s_frame_done), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
